// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe stage family: the beat-count width helper.
package pipe_pkg;

    // Width needed to hold a beat count in the range 0..n.
    function automatic int unsigned cw_for(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_packer.sv
// Width-up converter: packs N L-bit beats (first beat in the LSBs) into one registered
// N*L-bit word; last_f closes a word early, and unused upper slots read as zero.
module pipe_packer
    import pipe_pkg::*;
#(
    parameter  int unsigned L  = 8,
    parameter  int unsigned N  = 4,
    localparam int unsigned CW = cw_for(N)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ready_f,
    input  logic            valid_f,
    input  logic [L-1:0]    data_f,
    input  logic            last_f,
    input  logic            ready_b,
    output logic            valid_b,
    output logic [N*L-1:0]  data_b,
    output logic [CW-1:0]   count_b,
    output logic            last_b
);

    logic [CW-1:0]      cnt_q;
    logic [(N-1)*L-1:0] acc_q;
    logic               valid_q;
    logic [N*L-1:0]     data_q;
    logic [CW-1:0]      count_q;
    logic               last_q;

    logic               in_xfer;
    logic               out_xfer;
    logic               close;
    logic [N-2:0]       acc_we;
    logic [N*L-1:0]     acc_ext;
    logic [N*L-1:0]     word_d;

    assign ready_f  = ~valid_q | ready_b;
    assign in_xfer  = valid_f & ready_f;
    assign out_xfer = valid_q & ready_b;
    assign close    = in_xfer & (last_f | (cnt_q == CW'(N - 1)));
    assign acc_ext  = {{L{1'b0}}, acc_q};

    // Closing word: stored slots below cnt, the incoming beat at cnt, zeros above.
    always_comb begin
        word_d = '0;
        acc_we = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (CW'(k) < cnt_q) begin
                word_d[k*L +: L] = acc_ext[k*L +: L];
            end else if (CW'(k) == cnt_q) begin
                word_d[k*L +: L] = data_f;
            end
        end
        for (int unsigned k = 0; k < N - 1; k++) begin
            acc_we[k] = in_xfer & ~close & (cnt_q == CW'(k));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (close) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            if (in_xfer) begin
                cnt_q <= cnt_q + CW'(1);
            end
            for (int unsigned k = 0; k < N - 1; k++) begin
                if (acc_we[k]) begin
                    acc_q[k*L +: L] <= data_f;
                end
            end
        end
    end

    // A close can only happen while ready_f=1, so a stalled word is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
            last_q  <= 1'b0;
        end else if (close) begin
            valid_q <= 1'b1;
            data_q  <= word_d;
            count_q <= cnt_q + CW'(1);
            last_q  <= last_f;
        end else if (out_xfer) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_b = valid_q;
    assign data_b  = data_q;
    assign count_b = count_q;
    assign last_b  = last_q;

endmodule

// File: tb/tb_pipe_packer.sv
// Directed and scoreboard-checked stimulus for pipe_packer at L=8, N=4.
module tb_pipe_packer;

    localparam int unsigned L = 8;
    localparam int unsigned N = 4;
    localparam int NBEATS     = 10000;
    localparam int MAXCYC     = 60000;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready_f;
    logic          valid_f;
    logic [L-1:0]  data_f;
    logic          last_f;
    logic          ready_b;
    logic          valid_b;
    logic [N*L-1:0] data_b;
    logic [2:0]    count_b;
    logic          last_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  c;
        logic        l;
    } word_t;

    word_t sb[$];

    pipe_packer #(.L(L), .N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .ready_f (ready_f),
        .valid_f (valid_f),
        .data_f  (data_f),
        .last_f  (last_f),
        .ready_b (ready_b),
        .valid_b (valid_b),
        .data_b  (data_b),
        .count_b (count_b),
        .last_b  (last_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d, input logic l);
        valid_f = 1'b1;
        data_f  = d;
        last_f  = l;
        tick();
        valid_f = 1'b0;
        last_f  = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic v, input logic [31:0] d,
                            input logic [2:0] c, input logic l);
        chk({tag, "_valid"}, valid_b, v);
        chk({tag, "_data"},  data_b,  d);
        chk({tag, "_count"}, count_b, c);
        chk({tag, "_last"},  last_b,  l);
    endtask

    initial begin
        logic [31:0] held_d;
        logic [31:0] pacc;
        logic [7:0]  d_snap;
        logic        l_snap, in_x, out_x;
        logic [31:0] ob_d;
        logic [2:0]  ob_c;
        logic        ob_l;
        word_t       w;
        int          pcnt, sent, cyc, pushed, popped;

        rst     = 1'b1;
        valid_f = 1'b0;
        data_f  = '0;
        last_f  = 1'b0;
        ready_b = 1'b0;
        tick();
        tick();
        chk_word("reset", 1'b0, 32'h0, 3'd0, 1'b0);
        chk("reset_ready_f", ready_f, 1'b1);
        rst = 1'b0;

        // Reset mid-word: the two stored beats must be discarded.
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", valid_b, 1'b0);
        chk("midrst_count", count_b, 3'd0);
        chk("midrst_ready_f", ready_f, 1'b1);
        tick();
        rst = 1'b0;
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b0);
        chk("acc_no_output", valid_b, 1'b0);
        beat(8'h44, 1'b0);
        chk_word("full1", 1'b1, 32'h44332211, 3'd4, 1'b0);

        // Drain, then stream 8 beats with ready_b=1.
        ready_b = 1'b1;
        tick();
        chk("drain_valid", valid_b, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            valid_f = 1'b1;
            data_f  = 8'(i);
            last_f  = 1'b0;
            #1;
            chk("stream_ready_f", ready_f, 1'b1);
            tick();
            if (i == 4) chk_word("stream_w1", 1'b1, 32'h04030201, 3'd4, 1'b0);
            else if (i == 8) chk_word("stream_w2", 1'b1, 32'h08070605, 3'd4, 1'b0);
            else chk("stream_gap_valid", valid_b, 1'b0);
        end
        valid_f = 1'b0;
        tick();
        chk("stream_end_valid", valid_b, 1'b0);

        // Partial words and last_f on the final slot.
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b1);
        chk_word("partial2", 1'b1, 32'h0000BBAA, 3'd2, 1'b1);
        beat(8'hCC, 1'b1);
        chk_word("partial1", 1'b1, 32'h000000CC, 3'd1, 1'b1);
        beat(8'h9A, 1'b0);
        chk("partial_drain", valid_b, 1'b0);
        beat(8'h9B, 1'b0);
        beat(8'h9C, 1'b0);
        beat(8'h9D, 1'b1);
        chk_word("last_at_n", 1'b1, 32'h9D9C9B9A, 3'd4, 1'b1);
        tick();

        // Backpressure: word stays frozen and offered beats are refused.
        ready_b = 1'b0;
        beat(8'h10, 1'b0);
        beat(8'h11, 1'b0);
        beat(8'h12, 1'b0);
        beat(8'h13, 1'b0);
        chk_word("bp_word", 1'b1, 32'h13121110, 3'd4, 1'b0);
        chk("bp_ready_f", ready_f, 1'b0);
        valid_f = 1'b1;
        data_f  = 8'hEE;
        last_f  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_word("bp_hold", 1'b1, 32'h13121110, 3'd4, 1'b0);
            chk("bp_hold_ready_f", ready_f, 1'b0);
        end
        valid_f = 1'b0;
        last_f  = 1'b0;
        ready_b = 1'b1;
        #1;
        chk("bp_release_ready_f", ready_f, 1'b1);
        tick();
        chk("bp_drained", valid_b, 1'b0);
        beat(8'h01, 1'b1);
        chk_word("bp_no_junk", 1'b1, 32'h00000001, 3'd1, 1'b1);
        tick();

        // Drain and close in the same cycle.
        ready_b = 1'b0;
        beat(8'h21, 1'b0);
        beat(8'h22, 1'b0);
        beat(8'h23, 1'b0);
        beat(8'h24, 1'b0);
        tick();
        tick();
        chk_word("dc_w1_held", 1'b1, 32'h24232221, 3'd4, 1'b0);
        ready_b = 1'b1;
        valid_f = 1'b1;
        data_f  = 8'h77;
        last_f  = 1'b1;
        #1;
        chk("dc_ready_f", ready_f, 1'b1);
        tick();
        valid_f = 1'b0;
        last_f  = 1'b0;
        chk_word("dc_w2", 1'b1, 32'h00000077, 3'd1, 1'b1);
        tick();
        chk("dc_drained", valid_b, 1'b0);

        // Random traffic against a scoreboard built from the accepted beats.
        pacc   = '0;
        pcnt   = 0;
        sent   = 0;
        cyc    = 0;
        pushed = 0;
        popped = 0;
        held_d = '0;
        while ((sent < NBEATS || sb.size() > 0 || valid_b) && cyc < MAXCYC) begin
            if (sent < NBEATS) begin
                valid_f = ($urandom_range(3) != 0);
                data_f  = 8'($urandom);
                last_f  = ($urandom_range(4) == 0) || (sent == NBEATS - 1);
                ready_b = ($urandom_range(3) != 0);
            end else begin
                valid_f = 1'b0;
                last_f  = 1'b0;
                ready_b = 1'b1;
            end
            #2;
            chk("rand_ready_f", ready_f, !valid_b || ready_b);
            in_x   = valid_f && ready_f;
            out_x  = valid_b && ready_b;
            d_snap = data_f;
            l_snap = last_f;
            ob_d   = data_b;
            ob_c   = count_b;
            ob_l   = last_b;
            tick();
            cyc++;
            if (out_x) begin
                chk("rand_word_pending", popped < pushed, 1'b1);
                if (sb.size() > 0) begin
                    w = sb.pop_front();
                    popped++;
                    chk("rand_data", ob_d, w.d);
                    chk("rand_count", ob_c, w.c);
                    chk("rand_last", ob_l, w.l);
                end
            end
            if (in_x) begin
                pacc[pcnt*8 +: 8] = d_snap;
                pcnt++;
                sent++;
                if (l_snap || pcnt == N) begin
                    sb.push_back('{d: pacc, c: 3'(pcnt), l: l_snap});
                    pushed++;
                    pacc = '0;
                    pcnt = 0;
                end
            end
        end
        chk("rand_no_timeout", cyc < MAXCYC, 1'b1);
        chk("rand_all_beats_sent", sent, NBEATS);
        chk("rand_sb_empty", sb.size(), 0);
        chk("rand_words_balanced", popped, pushed);
        chk("rand_end_valid", valid_b, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
